ccip_mmio_requester: RTL and testbench
======================================

// Module: ccip_mmio_requester
// PURPOSE
//  Host-side MMIO initiator for CCI-P. Accepts simple read/write commands, drives
//  c0 MMIO request strobes and headers toward an AFU, then collects the matching
//  c2 MMIO read response. Used in loopback self-test and co-simulation to exercise
//  the AFU CSR space (DFH at 0x0, AFU_ID_L at 0x2, AFU_ID_H at 0x4).
// PARAMETERS
//  TIMEOUT_CYCLES  512  cycles to wait for a c2 response before flagging a timeout (>=2)
//  TID_W           9    width of the MMIO transaction ID
// PORTS
//  pClk                   in   1      CCI-P clock, all logic on rising edge
//  pck_cp2af_softReset_n  in   1      asynchronous, active-low reset
//  cmd_valid              in   1      command offered
//  cmd_ready              out  1      command accepted when valid&ready
//  cmd_write              in   1      1=MMIO write, 0=MMIO read
//  cmd_addr               in   16     MMIO address in 32-bit word units
//  cmd_len64              in   1      1=64-bit access, 0=32-bit access
//  cmd_wdata              in   64     write data (32-bit writes use [31:0])
//  mmio_rd_valid          out  1      c0 mmioRdValid strobe
//  mmio_wr_valid          out  1      c0 mmioWrValid strobe
//  mmio_hdr_address       out  16     c0 MMIO header address
//  mmio_hdr_length        out  2      c0 MMIO header length (0=4B, 1=8B)
//  mmio_hdr_tid           out  TID_W  c0 MMIO header tid
//  mmio_wdata             out  64     c0 write data
//  c2_rsp_valid           in   1      c2 mmioRdValid from the AFU
//  c2_rsp_tid             in   TID_W  c2 response tid
//  c2_rsp_data            in   64     c2 response data
//  rd_done                out  1      one-cycle pulse: read finished
//  rd_data                out  64     response data, valid with rd_done (0 on timeout)
//  rd_timeout             out  1      valid with rd_done: 1 = no response arrived
//  err_count              out  16     saturating count of unexpected/mismatched c2 responses
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=0 for one cycle after deassert, then 1 in IDLE;
//   next_tid=0, timeout counter=0, err_count=0. Reset mid-read abandons it, no rd_done.
//  FSM states: IDLE, ISSUE, WAIT_RSP.
//  - IDLE: cmd_ready=1. On accept, register addr, len and data; go to ISSUE.
//  - ISSUE: cmd_ready=0. Exactly one cycle with mmio_rd_valid or mmio_wr_valid=1.
//    Header fields are stable that cycle and hold their value afterwards.
//    Write: tid=next_tid, return to IDLE (no response expected).
//    Read: tid=next_tid, latch expected tid, clear counter, go to WAIT_RSP.
//    next_tid increments mod 2^TID_W after every issued request, read or write.
//  - WAIT_RSP: counter increments each cycle.
//    c2_rsp_valid with tid==expected: rd_done=1, rd_data=c2_rsp_data, rd_timeout=0
//     on the next cycle (1-cycle registered latency); go to IDLE.
//    Counter reaches TIMEOUT_CYCLES-1 with no match: rd_done=1, rd_timeout=1,
//     rd_data=0; go to IDLE. A match arriving in that same cycle wins over timeout.
//  c2_rsp_valid in IDLE or ISSUE, or with a mismatched tid in WAIT_RSP: ignored;
//   err_count += 1, saturating at 0xFFFF. A late response after a timeout also counts.
//  Back-to-back: a new command is accepted in the cycle after a write issue or after
//   rd_done. Minimum command spacing is 2 cycles.
//  32-bit read: rd_data = {32'h0, c2_rsp_data[31:0]}.
// TESTING
//  Read addr 0x0 len64, AFU answers tid 0 after 3 cycles with 0x1000_0100_0000_0000
//   -> one rd_valid pulse with addr=0,len=1,tid=0; rd_done 1 cycle later, same data, timeout=0.
//  Reads 0x2 then 0x4 back-to-back -> tids 1,2; rd_data = AFU_ID low/high words in order.
//  Write 0x110 data 0xDEAD_BEEF len32 -> single wr_valid, addr=0x110, len=0, wdata[31:0]
//   = 0xDEADBEEF; cmd_ready back to 1 the next cycle.
//  Read with no response -> rd_done exactly TIMEOUT_CYCLES cycles after the issue cycle,
//   rd_timeout=1, rd_data=0. A late response then raises err_count to 1.
//  Wrong-tid response, then correct tid -> err_count=1, rd_done carries correct data.
//  512 issues wrap tid 511->0. Reset asserted in WAIT_RSP -> no rd_done, all outputs 0, tid=0.

Source files
------------

// File: rtl/ccip_mmio_requester.sv
`default_nettype none
// ============================================================================
// Module   : ccip_mmio_requester
// Brief    : Host-side CCI-P MMIO initiator. Issues one c0 MMIO read/write per
//            command and collects the tid-matched c2 read response.
// Revision : 1.0 - initial release
// ============================================================================
module ccip_mmio_requester #(
   parameter int TIMEOUT_CYCLES = 512,
   parameter int TID_W          = 9
) (
   input  logic             pClk,
   input  logic             pck_cp2af_softReset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [15:0]      cmd_addr,
   input  logic             cmd_len64,
   input  logic [63:0]      cmd_wdata,
   output logic             mmio_rd_valid,
   output logic             mmio_wr_valid,
   output logic [15:0]      mmio_hdr_address,
   output logic [1:0]       mmio_hdr_length,
   output logic [TID_W-1:0] mmio_hdr_tid,
   output logic [63:0]      mmio_wdata,
   input  logic             c2_rsp_valid,
   input  logic [TID_W-1:0] c2_rsp_tid,
   input  logic [63:0]      c2_rsp_data,
   output logic             rd_done,
   output logic [63:0]      rd_data,
   output logic             rd_timeout,
   output logic [15:0]      err_count
);

   localparam int               CNT_W          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_started;
   logic             r_write;
   logic [15:0]      r_addr;
   logic             r_len64;
   logic [63:0]      r_wdata;
   logic [TID_W-1:0] r_tid;
   logic [TID_W-1:0] r_nextTid;
   logic [TID_W-1:0] r_expTid;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rdDone;
   logic [63:0]      r_rdData;
   logic             r_rdTimeout;
   logic [15:0]      r_errCount;

   logic             w_accept;
   logic             w_match;
   logic             w_timeout;
   logic             w_unexpected;
   logic [63:0]      w_rspData;

   assign w_accept     = cmd_valid & cmd_ready;
   assign w_match      = (r_state == ST_WAIT_RSP) & c2_rsp_valid & (c2_rsp_tid == r_expTid);
   // A matching response in the final wait cycle takes priority over the timeout.
   assign w_timeout    = (r_state == ST_WAIT_RSP) & ~w_match & (r_cnt == c_TIMEOUT_LAST);
   assign w_unexpected = c2_rsp_valid & ~w_match;
   assign w_rspData    = r_len64 ? c2_rsp_data : {32'h0, c2_rsp_data[31:0]};

   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      cmd_ready     = 1'b0;
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = r_started;
            if (cmd_valid && r_started) begin
               w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mmio_rd_valid = ~r_write;
            mmio_wr_valid = r_write;
            w_nextState   = r_write ? ST_IDLE : ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (w_match || w_timeout) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Counter starts at 0 in the issue cycle so the timeout lands TIMEOUT_CYCLES after it.
   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         r_started   <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_len64     <= 1'b0;
         r_wdata     <= '0;
         r_tid       <= '0;
         r_nextTid   <= '0;
         r_expTid    <= '0;
         r_cnt       <= '0;
         r_rdDone    <= 1'b0;
         r_rdData    <= '0;
         r_rdTimeout <= 1'b0;
         r_errCount  <= '0;
      end else begin
         r_started <= 1'b1;
         if (w_accept) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_len64 <= cmd_len64;
            r_wdata <= cmd_len64 ? cmd_wdata : {32'h0, cmd_wdata[31:0]};
            r_tid   <= r_nextTid;
            r_cnt   <= '0;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == ST_ISSUE) begin
            r_nextTid <= r_nextTid + 1'b1;
            if (!r_write) begin
               r_expTid <= r_tid;
            end
         end
         r_rdDone    <= w_match | w_timeout;
         r_rdTimeout <= w_timeout;
         if (w_match) begin
            r_rdData <= w_rspData;
         end else if (w_timeout) begin
            r_rdData <= '0;
         end
         if (w_unexpected && (r_errCount != 16'hFFFF)) begin
            r_errCount <= r_errCount + 16'd1;
         end
      end
   end

   assign mmio_hdr_address = r_addr;
   assign mmio_hdr_length  = {1'b0, r_len64};
   assign mmio_hdr_tid     = r_tid;
   assign mmio_wdata       = r_wdata;
   assign rd_done          = r_rdDone;
   assign rd_data          = r_rdData;
   assign rd_timeout       = r_rdTimeout;
   assign err_count        = r_errCount;

endmodule
`default_nettype wire

// File: tb/tb_ccip_mmio_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccip_mmio_requester
// Brief    : Scoreboard bench: stimulus pushes expected c0 requests and read
//            completions, a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccip_mmio_requester;

   localparam int TIMEOUT = 16;
   localparam int TID_W   = 9;

   typedef struct {
      logic             write;
      logic [15:0]      addr;
      logic             len64;
      logic [TID_W-1:0] tid;
      logic [63:0]      wdata;
   } reqExp_t;

   typedef struct {
      logic [63:0] data;
      logic        timeout;
      int          delta;
   } doneExp_t;

   logic             pClk = 1'b0;
   logic             pck_cp2af_softReset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_write = 1'b0;
   logic [15:0]      cmd_addr = '0;
   logic             cmd_len64 = 1'b0;
   logic [63:0]      cmd_wdata = '0;
   logic             mmio_rd_valid;
   logic             mmio_wr_valid;
   logic [15:0]      mmio_hdr_address;
   logic [1:0]       mmio_hdr_length;
   logic [TID_W-1:0] mmio_hdr_tid;
   logic [63:0]      mmio_wdata;
   logic             c2_rsp_valid = 1'b0;
   logic [TID_W-1:0] c2_rsp_tid = '0;
   logic [63:0]      c2_rsp_data = '0;
   logic             rd_done;
   logic [63:0]      rd_data;
   logic             rd_timeout;
   logic [15:0]      err_count;

   reqExp_t          reqQ[$];
   doneExp_t         doneQ[$];
   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               issueCyc = 0;
   logic [TID_W-1:0] mTid = '0;
   logic [15:0]      mErr = '0;

   ccip_mmio_requester #(.TIMEOUT_CYCLES(TIMEOUT), .TID_W(TID_W)) dut (
      .pClk                  (pClk),
      .pck_cp2af_softReset_n (pck_cp2af_softReset_n),
      .cmd_valid             (cmd_valid),
      .cmd_ready             (cmd_ready),
      .cmd_write             (cmd_write),
      .cmd_addr              (cmd_addr),
      .cmd_len64             (cmd_len64),
      .cmd_wdata             (cmd_wdata),
      .mmio_rd_valid         (mmio_rd_valid),
      .mmio_wr_valid         (mmio_wr_valid),
      .mmio_hdr_address      (mmio_hdr_address),
      .mmio_hdr_length       (mmio_hdr_length),
      .mmio_hdr_tid          (mmio_hdr_tid),
      .mmio_wdata            (mmio_wdata),
      .c2_rsp_valid          (c2_rsp_valid),
      .c2_rsp_tid            (c2_rsp_tid),
      .c2_rsp_data           (c2_rsp_data),
      .rd_done               (rd_done),
      .rd_data               (rd_data),
      .rd_timeout            (rd_timeout),
      .err_count             (err_count)
   );

   always #5 pClk = ~pClk;
   always @(posedge pClk) cyc <= cyc + 1;

   // Monitor: every c0 strobe and every rd_done must match the next queued expectation.
   always @(negedge pClk) begin
      if (pck_cp2af_softReset_n) begin
         if (mmio_rd_valid || mmio_wr_valid) begin
            checks++;
            if (reqQ.size() == 0) begin
               errors++;
               $display("FAIL req_unexpected: rd=%0b wr=%0b addr=%h tid=%0d, required no request", mmio_rd_valid, mmio_wr_valid, mmio_hdr_address, mmio_hdr_tid);
            end else begin
               reqExp_t e;
               e = reqQ.pop_front();
               if (mmio_rd_valid !== ~e.write || mmio_wr_valid !== e.write ||
                   mmio_hdr_address !== e.addr || mmio_hdr_length !== {1'b0, e.len64} ||
                   mmio_hdr_tid !== e.tid ||
                   (e.write && mmio_wdata[31:0] !== e.wdata[31:0]) ||
                   (e.write && e.len64 && mmio_wdata !== e.wdata)) begin
                  errors++;
                  $display("FAIL req_fields: got rd=%0b wr=%0b addr=%h len=%0d tid=%0d wdata=%h, required wr=%0b addr=%h len=%0d tid=%0d wdata=%h",
                           mmio_rd_valid, mmio_wr_valid, mmio_hdr_address, mmio_hdr_length, mmio_hdr_tid, mmio_wdata,
                           e.write, e.addr, e.len64, e.tid, e.wdata);
               end
               if (!e.write) issueCyc = cyc;
            end
         end
         if (rd_done) begin
            checks++;
            if (doneQ.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: rd_done with data=%h timeout=%0b, required no completion", rd_data, rd_timeout);
            end else begin
               doneExp_t d;
               d = doneQ.pop_front();
               if (rd_data !== d.data || rd_timeout !== d.timeout || (cyc - issueCyc) != d.delta) begin
                  errors++;
                  $display("FAIL done_fields: got data=%h timeout=%0b latency=%0d, required data=%h timeout=%0b latency=%0d",
                           rd_data, rd_timeout, cyc - issueCyc, d.data, d.timeout, d.delta);
               end
            end
         end
      end
   end

   task automatic checkBit(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0b, required %0b", name, got, req);
      end
   endtask

   task automatic checkAllZero(input string name);
      logic [237:0] all;
      all = {cmd_ready, mmio_rd_valid, mmio_wr_valid, mmio_hdr_address, mmio_hdr_length,
             mmio_hdr_tid, mmio_wdata, rd_done, rd_data, rd_timeout, err_count, 46'h0};
      checks++;
      if (all !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h, required all zero", name, all);
      end
   endtask

   task automatic checkErr(input string name);
      @(negedge pClk);
      checks++;
      if (err_count !== mErr) begin
         errors++;
         $display("FAIL %s: err_count got %0d, required %0d", name, err_count, mErr);
      end
      @(posedge pClk); #1;
   endtask

   // Reset release: cmd_ready low for one cycle, then high.
   task automatic releaseReset();
      @(posedge pClk); #1;
      pck_cp2af_softReset_n = 1'b1;
      @(negedge pClk);
      checkBit("ready_first_cycle", cmd_ready, 1'b0);
      @(negedge pClk);
      checkBit("ready_idle", cmd_ready, 1'b1);
      @(posedge pClk); #1;
   endtask

   task automatic sendCmd(input logic wr, input logic [15:0] addr, input logic len,
                          input logic [63:0] data, output logic [TID_W-1:0] tid);
      reqExp_t e;
      int n = 0;
      e.write = wr; e.addr = addr; e.len64 = len; e.tid = mTid; e.wdata = data;
      reqQ.push_back(e);
      tid  = mTid;
      mTid = mTid + 1'b1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len64 = len; cmd_wdata = data;
      @(negedge pClk);
      while (!cmd_ready && n < 50) begin
         @(negedge pClk);
         n++;
      end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL cmd_accept: cmd_ready got 0 for %0d cycles, required 1", n);
      end
      @(posedge pClk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic waitRdValid();
      int n = 0;
      @(negedge pClk);
      while (!mmio_rd_valid && n < 10) begin
         @(negedge pClk);
         n++;
      end
      if (!mmio_rd_valid) begin
         checks++; errors++;
         $display("FAIL rd_valid_wait: mmio_rd_valid got 0, required 1 within 10 cycles");
      end
   endtask

   task automatic driveRsp(input logic [TID_W-1:0] tid, input logic [63:0] data);
      c2_rsp_valid = 1'b1; c2_rsp_tid = tid; c2_rsp_data = data;
      @(posedge pClk); #1;
      c2_rsp_valid = 1'b0;
   endtask

   task automatic doRead(input logic [15:0] addr, input logic len, input int d,
                         input logic [63:0] rsp, input bit respond, input bit badFirst,
                         output logic [TID_W-1:0] tid);
      doneExp_t e;
      int n = 0;
      sendCmd(1'b0, addr, len, 64'h0, tid);
      e.data    = respond ? (len ? rsp : {32'h0, rsp[31:0]}) : 64'h0;
      e.timeout = ~respond;
      e.delta   = respond ? (badFirst ? 4 : d + 1) : TIMEOUT;
      doneQ.push_back(e);
      waitRdValid();
      if (respond) begin
         if (badFirst) begin
            @(posedge pClk); #1;
            driveRsp(tid ^ 9'd1, ~rsp);
            mErr = mErr + 16'd1;
            @(posedge pClk); #1;
            driveRsp(tid, rsp);
         end else begin
            repeat (d) @(posedge pClk);
            #1;
            driveRsp(tid, rsp);
         end
      end
      do begin
         @(negedge pClk);
         n++;
      end while (!rd_done && n < TIMEOUT + 10);
      if (!rd_done) begin
         checks++; errors++;
         $display("FAIL rd_done_wait: rd_done got 0, required 1 within %0d cycles", TIMEOUT + 10);
      end
      @(posedge pClk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [TID_W-1:0] tid;
      repeat (3) @(posedge pClk);
      @(negedge pClk);
      checkAllZero("reset_outputs");
      releaseReset();

      // DFH read, AFU answers tid 0 three cycles later.
      doRead(16'h0, 1'b1, 3, 64'h1000_0100_0000_0000, 1'b1, 1'b0, tid);
      // AFU_ID low/high words back-to-back.
      doRead(16'h2, 1'b1, 1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, tid);
      doRead(16'h4, 1'b1, 2, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, tid);

      // 32-bit write; ready drops in the issue cycle and returns the next.
      sendCmd(1'b1, 16'h110, 1'b0, 64'h0000_0000_DEAD_BEEF, tid);
      @(negedge pClk);
      checkBit("ready_in_issue", cmd_ready, 1'b0);
      @(negedge pClk);
      checkBit("ready_after_write", cmd_ready, 1'b1);
      @(posedge pClk); #1;

      // 32-bit read zero-extends the response.
      doRead(16'h8, 1'b0, 2, 64'hAAAA_BBBB_1234_5678, 1'b1, 1'b0, tid);

      // Timeout, then a late response counts as an error.
      doRead(16'h6, 1'b1, 0, 64'h0, 1'b0, 1'b0, tid);
      checkErr("err_before_late");
      driveRsp(tid, 64'h5555_5555_5555_5555);
      mErr = mErr + 16'd1;
      checkErr("err_late_rsp");

      // Wrong tid first, then correct tid.
      doRead(16'h2, 1'b1, 0, 64'h0BAD_CAFE_0000_0001, 1'b1, 1'b1, tid);
      checkErr("err_wrong_tid");

      sendCmd(1'b1, 16'h20, 1'b1, 64'h1122_3344_5566_7788, tid);

      // 512 writes wrap the tid all the way round.
      for (int i = 0; i < 512; i++) begin
         sendCmd(1'b1, 16'(i), 1'(i), {32'(i * 3), 32'(i ^ 32'h5A5A)}, tid);
      end
      doRead(16'h4, 1'b1, 1, 64'h7777_6666_5555_4444, 1'b1, 1'b0, tid);

      // Reset in WAIT_RSP abandons the read.
      sendCmd(1'b0, 16'h4, 1'b1, 64'h0, tid);
      waitRdValid();
      repeat (2) @(posedge pClk);
      #1;
      pck_cp2af_softReset_n = 1'b0;
      @(negedge pClk);
      checkAllZero("reset_mid_read");
      mTid = '0;
      mErr = '0;
      releaseReset();
      sendCmd(1'b1, 16'h30, 1'b0, 64'h0000_0000_5A5A_5A5A, tid);
      repeat (3) @(posedge pClk);
      #1;
      checkErr("err_after_reset");

      repeat (TIMEOUT + 4) @(posedge pClk);
      checks++;
      if (reqQ.size() != 0 || doneQ.size() != 0) begin
         errors++;
         $display("FAIL queues_drained: pending req=%0d done=%0d, required 0 and 0", reqQ.size(), doneQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
